// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter that shares one memory_driver read channel among NUM_REQ burst requesters.
// One StartRead per grant; returned beats are steered back to the granted requester.
module mem_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_burst,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ-1:0]            rsp_last,
    output logic                          mem_start_read,
    output logic [ADDR_WIDTH-1:0]         mem_read_addr,
    output logic [7:0]                    mem_read_burst,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    input  logic                          mem_read_valid,
    input  logic                          mem_end_read,
    output logic                          busy,
    output logic                          err_protocol
);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DRAIN} state_t;

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              burst_q, burst_d;
    logic [7:0]              count_q, count_d;
    logic                    start_q, start_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]      rsp_last_q, rsp_last_d;
    logic                    err_q, err_d;

    logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [7:0]              burst_arr [NUM_REQ];
    logic                    any_req;
    logic [IDX_W-1:0]        rr_win;
    logic [IDX_W:0]          scan_sum;
    logic                    last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign burst_arr[gi] = req_burst[gi*8 +: 8];
        end
    endgenerate

    // First pending requester strictly after the last winner, wrapping around.
    always_comb begin
        any_req  = 1'b0;
        rr_win   = '0;
        scan_sum = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            if (!any_req && req_valid[scan_sum[IDX_W-1:0]]) begin
                any_req = 1'b1;
                rr_win  = scan_sum[IDX_W-1:0];
            end
        end
    end

    assign last_beat = (count_q == burst_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        burst_d     = burst_q;
        count_d     = count_q;
        start_d     = 1'b0;
        ack_d       = '0;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = '0;
        rsp_last_d  = '0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (mem_read_valid) begin
                    err_d = 1'b1;
                end
                if (any_req) begin
                    grant_d       = rr_win;
                    ptr_d         = rr_win;
                    addr_d        = addr_arr[rr_win];
                    burst_d       = burst_arr[rr_win];
                    start_d       = 1'b1;
                    ack_d[rr_win] = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_read_valid) begin
                    err_d = 1'b1;
                end
                count_d = 8'd0;
                state_d = BURST;
            end
            BURST: begin
                if (mem_read_valid) begin
                    rsp_data_d           = mem_read_data;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_last_d[grant_q]  = last_beat;
                    count_d              = count_q + 8'd1;
                end
                // Compare happens before the increment, so burst 255 yields 256 beats.
                if (mem_read_valid && last_beat) begin
                    state_d = mem_end_read ? IDLE : DRAIN;
                end else if (mem_end_read) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (mem_read_valid) begin
                    err_d = 1'b1;
                end
                if (mem_end_read) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            addr_q      <= '0;
            burst_q     <= '0;
            count_q     <= '0;
            start_q     <= 1'b0;
            ack_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            rsp_last_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            burst_q     <= burst_d;
            count_q     <= count_d;
            start_q     <= start_d;
            ack_q       <= ack_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            err_q       <= err_d;
        end
    end

    assign req_ack        = ack_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_last       = rsp_last_q;
    assign mem_start_read = start_q;
    assign mem_read_addr  = addr_q;
    assign mem_read_burst = burst_q;
    assign busy           = (state_q != IDLE);
    assign err_protocol   = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomised scoreboard bench for mem_read_arbiter: a driver model predicts each grant and
// queues the expected beats; an independent monitor pops and compares every response.
module tb_mem_read_arbiter;

    localparam int NR = 4;
    localparam int AW = 33;
    localparam int DW = 256;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    logic                 clk;
    logic                 reset_n;
    logic [NR-1:0]        req_valid;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*8-1:0]      req_burst;
    logic [NR-1:0]        req_ack;
    logic [DW-1:0]        rsp_data;
    logic [NR-1:0]        rsp_valid;
    logic [NR-1:0]        rsp_last;
    logic                 mem_start_read;
    logic [AW-1:0]        mem_read_addr;
    logic [7:0]           mem_read_burst;
    logic [DW-1:0]        mem_read_data;
    logic                 mem_read_valid;
    logic                 mem_end_read;
    logic                 busy;
    logic                 err_protocol;

    mem_read_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_burst      (req_burst),
        .req_ack        (req_ack),
        .rsp_data       (rsp_data),
        .rsp_valid      (rsp_valid),
        .rsp_last       (rsp_last),
        .mem_start_read (mem_start_read),
        .mem_read_addr  (mem_read_addr),
        .mem_read_burst (mem_read_burst),
        .mem_read_data  (mem_read_data),
        .mem_read_valid (mem_read_valid),
        .mem_end_read   (mem_end_read),
        .busy           (busy),
        .err_protocol   (err_protocol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   rsp_cnt  [NR];
    int   last_cnt [NR];
    int   rr_last = NR - 1;
    int   last_end_cyc = 0;
    int   start_gap = 0;
    int   beats_driven = 0;
    int   grant_cnt = 0;
    int   abort_after = -1;
    bit   stray_req = 1'b0;
    bit   expect_idle = 1'b0;

    // Request lines as the DUT sampled them at each rising edge.
    logic [NR-1:0]    snap_valid;
    logic [NR*AW-1:0] snap_addr;
    logic [NR*8-1:0]  snap_burst;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        snap_valid <= req_valid;
        snap_addr  <= req_addr;
        snap_burst <= req_burst;
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Memory driver model and grant predictor.
    initial begin : driver
        int            win;
        int            blen;
        int            b;
        int            j;
        bit            same_end;
        bit            aborted;
        logic [AW-1:0] eaddr;
        logic [NR-1:0] exp_oh;
        exp_t          e;
        mem_read_valid = 1'b0;
        mem_end_read   = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clk);
            mem_read_valid = 1'b0;
            mem_end_read   = 1'b0;
            if (!reset_n) begin
                rr_last     = NR - 1;
                expect_idle = 1'b0;
                continue;
            end
            if (expect_idle) begin
                chk(busy == 1'b0, "busy_after_end", 64'(busy), 64'd0);
                expect_idle = 1'b0;
            end
            if (stray_req) begin
                mem_read_valid = 1'b1;
                mem_read_data  = rand_data();
                stray_req      = 1'b0;
            end
            if (mem_start_read !== 1'b1) continue;
            grant_cnt++;
            start_gap = cyc - last_end_cyc;
            win = -1;
            for (int k = 1; k <= NR; k++) begin
                j = (rr_last + k) % NR;
                if (win < 0 && snap_valid[j]) win = j;
            end
            if (win < 0) begin
                chk(1'b0, "start_without_request", 64'(req_ack), 64'd0);
                continue;
            end
            rr_last = win;
            eaddr   = snap_addr[win*AW +: AW];
            blen    = int'(snap_burst[win*8 +: 8]);
            exp_oh  = '0;
            exp_oh[win] = 1'b1;
            $display("grant %0d addr 0x%0h burst %0d", win, eaddr, blen);
            chk(req_ack == exp_oh, "grant_ack", 64'(req_ack), 64'(exp_oh));
            chk(mem_read_addr == eaddr, "grant_addr", 64'(mem_read_addr), 64'(eaddr));
            chk(mem_read_burst == 8'(blen), "grant_burst", 64'(mem_read_burst), 64'(blen));
            chk(busy == 1'b1, "busy_in_issue", 64'(busy), 64'd1);
            same_end = 1'($urandom_range(1));
            aborted  = 1'b0;
            b = 0;
            while (b <= blen) begin
                @(negedge clk);
                mem_read_valid = 1'b0;
                mem_end_read   = 1'b0;
                if (!reset_n) begin
                    aborted = 1'b1;
                    rr_last = NR - 1;
                    break;
                end
                if (abort_after >= 0 && b == abort_after) begin
                    mem_end_read = 1'b1;
                    last_end_cyc = cyc;
                    expect_idle  = 1'b1;
                    aborted      = 1'b1;
                    break;
                end
                if ($urandom_range(3) == 0) continue;
                mem_read_valid = 1'b1;
                mem_read_data  = rand_data();
                e.idx  = win;
                e.data = mem_read_data;
                e.last = (b == blen);
                exp_q.push_back(e);
                beats_driven++;
                if (b == blen) begin
                    chk(mem_read_addr == eaddr, "addr_held", 64'(mem_read_addr), 64'(eaddr));
                    if (same_end) begin
                        mem_end_read = 1'b1;
                        last_end_cyc = cyc;
                        expect_idle  = 1'b1;
                    end
                end
                b++;
            end
            if (!aborted && !same_end) begin
                repeat ($urandom_range(2)) begin
                    @(negedge clk);
                    mem_read_valid = 1'b0;
                end
                @(negedge clk);
                mem_read_valid = 1'b0;
                mem_end_read   = 1'b1;
                last_end_cyc   = cyc;
                expect_idle    = 1'b1;
            end
        end
    end

    // Response monitor: every forwarded beat must match the head of the scoreboard.
    initial begin : monitor
        exp_t          e;
        logic [NR-1:0] exp_oh;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) continue;
            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i]) rsp_cnt[i]++;
                if (rsp_last[i])  last_cnt[i]++;
            end
            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    exp_oh = '0;
                    exp_oh[e.idx] = 1'b1;
                    $display("beat req %0d last %0d data 0x%0h", e.idx, e.last, rsp_data[31:0]);
                    chk(rsp_valid == exp_oh, "rsp_valid", 64'(rsp_valid), 64'(exp_oh));
                    chk(rsp_data == e.data, "rsp_data", rsp_data[63:0], e.data[63:0]);
                    chk(rsp_last == (e.last ? exp_oh : '0), "rsp_last", 64'(rsp_last),
                        64'(e.last ? exp_oh : '0));
                end
            end else if (rsp_last != '0) begin
                chk(1'b0, "last_without_valid", 64'(rsp_last), 64'd0);
            end
        end
    end

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [7:0] bl);
        req_valid[i]        = v;
        req_addr[i*AW +: AW] = a;
        req_burst[i*8 +: 8]  = bl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            rsp_cnt[i]  = 0;
            last_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input int i, input string name);
        int g = 0;
        @(negedge clk);
        while (!req_ack[i] && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk(g < 3000, name, 64'(g), 64'd3000);
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || exp_q.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk(g < 3000, name, 64'(g), 64'd3000);
        @(negedge clk);
    endtask

    initial begin : main
        int order [6];
        int n;
        int g;
        int base;
        int hold [NR];
        int tot;
        reset_n   = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_burst = '0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk({req_ack, rsp_valid, rsp_last, mem_start_read, busy, err_protocol} == '0,
            "reset_ctrl_outputs", 64'({req_ack, rsp_valid, rsp_last, mem_start_read, busy, err_protocol}), 64'd0);
        chk(mem_read_addr == '0 && mem_read_burst == '0 && rsp_data == '0, "reset_data_outputs",
            64'(mem_read_addr), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request: start one cycle after req_valid, 4 beats, last on the 4th.
        set_req(0, 1'b1, 33'h100, 8'd3);
        @(negedge clk);
        chk(mem_start_read == 1'b1, "single_start_latency", 64'(mem_start_read), 64'd1);
        chk(req_ack == 4'b0001, "single_ack", 64'(req_ack), 64'd1);
        req_valid[0] = 1'b0;
        wait_idle("single_idle_timeout");
        chk(rsp_cnt[0] == 4, "single_beats", 64'(rsp_cnt[0]), 64'd4);
        chk(last_cnt[0] == 1, "single_lasts", 64'(last_cnt[0]), 64'd1);

        // Round robin with every requester held high.
        do_reset();
        base = grant_cnt;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(32'h1000 * (i + 1)), 8'd1);
        n = 0;
        g = 0;
        while (n < 6 && g < 500) begin
            @(negedge clk);
            g++;
            if (req_ack != '0) begin
                chk($countones(req_ack) == 1, "rr_ack_onehot", 64'(req_ack), 64'd1);
                for (int i = 0; i < NR; i++) if (req_ack[i]) order[n] = i;
                n++;
            end
        end
        req_valid = '0;
        chk(n == 6, "rr_grant_timeout", 64'(n), 64'd6);
        for (int k = 0; k < n; k++) chk(order[k] == k % NR, "rr_order", 64'(order[k]), 64'(k % NR));
        wait_idle("rr_idle_timeout");
        chk(grant_cnt - base == 6, "rr_starts_per_ack", 64'(grant_cnt - base), 64'd6);
        chk(err_protocol == 1'b0, "rr_no_error", 64'(err_protocol), 64'd0);

        // Zero-length burst, held request: next grant two cycles after the end.
        do_reset();
        set_req(2, 1'b1, 33'h1_2345_6780, 8'd0);
        wait_ack(2, "zero_ack1_timeout");
        wait_ack(2, "zero_ack2_timeout");
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk(start_gap == 2, "zero_grant_gap", 64'(start_gap), 64'd2);
        wait_idle("zero_idle_timeout");
        chk(rsp_cnt[2] == 2 && last_cnt[2] == 2, "zero_beats_lasts", 64'(rsp_cnt[2]), 64'd2);

        // Maximum burst: 256 beats, one last.
        do_reset();
        set_req(1, 1'b1, 33'h0_0000_4000, 8'd255);
        wait_ack(1, "max_ack_timeout");
        req_valid[1] = 1'b0;
        wait_idle("max_idle_timeout");
        chk(rsp_cnt[1] == 256, "max_beats", 64'(rsp_cnt[1]), 64'd256);
        chk(last_cnt[1] == 1, "max_lasts", 64'(last_cnt[1]), 64'd1);

        // Early end_read after 2 of 4 beats.
        do_reset();
        abort_after = 2;
        set_req(0, 1'b1, 33'h200, 8'd3);
        wait_ack(0, "early_ack_timeout");
        req_valid[0] = 1'b0;
        wait_idle("early_idle_timeout");
        abort_after = -1;
        chk(err_protocol == 1'b1, "early_err", 64'(err_protocol), 64'd1);
        chk(rsp_cnt[0] == 2 && last_cnt[0] == 0, "early_beats_no_last", 64'(last_cnt[0]), 64'd0);

        // Stray beat in IDLE: flagged, never forwarded.
        do_reset();
        chk(err_protocol == 1'b0, "err_cleared_by_reset", 64'(err_protocol), 64'd0);
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        tot = 0;
        for (int i = 0; i < NR; i++) tot += rsp_cnt[i];
        chk(err_protocol == 1'b1, "stray_err", 64'(err_protocol), 64'd1);
        chk(tot == 0, "stray_not_forwarded", 64'(tot), 64'd0);

        // Asynchronous reset in the middle of an 8-beat burst.
        do_reset();
        base = beats_driven;
        set_req(2, 1'b1, 33'h1F0, 8'd7);
        wait_ack(2, "midrst_ack_timeout");
        req_valid[2] = 1'b0;
        g = 0;
        while (beats_driven < base + 2 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk(g < 200, "midrst_beat_timeout", 64'(g), 64'd200);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk({req_ack, rsp_valid, rsp_last, mem_start_read, busy, err_protocol} == '0,
            "midrst_ctrl_cleared", 64'({req_ack, rsp_valid, rsp_last, mem_start_read, busy}), 64'd0);
        chk(mem_read_addr == '0 && mem_read_burst == '0 && rsp_data == '0, "midrst_data_cleared",
            64'(mem_read_addr), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 33'h300, 8'd1);
        set_req(3, 1'b1, 33'h380, 8'd1);
        g = 0;
        @(negedge clk);
        while (req_ack == '0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk(req_ack == 4'b0001, "midrst_req0_first", 64'(req_ack), 64'd1);
        req_valid[0] = 1'b0;
        wait_ack(3, "midrst_ack3_timeout");
        req_valid[3] = 1'b0;
        wait_idle("midrst_idle_timeout");

        // Random traffic.
        do_reset();
        for (int i = 0; i < NR; i++) hold[i] = 0;
        repeat (2500) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (req_ack[i]) begin
                    set_req(i, 1'b0, AW'({$urandom, $urandom}), 8'($urandom_range(12)));
                    hold[i] = $urandom_range(6);
                end else if (!req_valid[i]) begin
                    if (hold[i] > 0) hold[i]--;
                    else if ($urandom_range(2) == 0)
                        set_req(i, 1'b1, AW'({$urandom, $urandom}), 8'($urandom_range(12)));
                end else if ($urandom_range(39) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        wait_idle("random_idle_timeout");
        chk(err_protocol == 1'b0, "random_no_error", 64'(err_protocol), 64'd0);
        chk(exp_q.size() == 0, "random_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
